// File: rtl/dilithium_host_driver_if.sv
// Signal bundle between the host driver and its environment: command/response,
// upstream source, downstream sink and the Dilithium core stream ports.
interface dilithium_host_driver_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_in_words;
    logic [CNT_W-1:0] cmd_out_words;

    logic             src_valid;
    logic             src_ready;
    logic [31:0]      src_data;

    logic             snk_valid;
    logic             snk_ready;
    logic [31:0]      snk_data;
    logic             snk_last;

    logic             start;
    logic [1:0]       mode;
    logic             valid_i;
    logic             ready_i;
    logic [31:0]      data_i;
    logic             valid_o;
    logic             ready_o;
    logic [31:0]      data_o;
    logic             done;
    logic             sign_reject;

    logic             busy;
    logic             rsp_valid;
    logic [1:0]       rsp_status;

    modport master (
        input  cmd_valid, cmd_mode, cmd_in_words, cmd_out_words,
               src_valid, src_data, snk_ready,
               ready_i, valid_o, data_o, done, sign_reject,
        output cmd_ready, src_ready, snk_valid, snk_data, snk_last,
               start, mode, valid_i, data_i, ready_o,
               busy, rsp_valid, rsp_status
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_in_words, cmd_out_words,
               src_valid, src_data, snk_ready,
               ready_i, valid_o, data_o, done, sign_reject,
        input  cmd_ready, src_ready, snk_valid, snk_data, snk_last,
               start, mode, valid_i, data_i, ready_o,
               busy, rsp_valid, rsp_status
    );
endinterface

// File: rtl/dilithium_host_driver.sv
// Host-side initiator for the Dilithium core: takes one command, pulses start,
// passes source/sink words straight through and reports a final status word.
module dilithium_host_driver #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    dilithium_host_driver_if.master bus
);

    localparam int                 TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);
    localparam logic               TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [1:0]         ST_OK   = 2'b00;
    localparam logic [1:0]         ST_REJ  = 2'b01;
    localparam logic [1:0]         ST_TO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_in_words;
    logic [CNT_W-1:0] r_out_words;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_done_seen;
    logic             r_rej_seen;
    logic [TO_W-1:0]  r_to_cnt;
    logic [1:0]       r_status;

    logic             w_in_open;
    logic             w_out_open;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_idle;
    logic             w_complete;
    logic             w_timeout;
    logic [1:0]       w_status_nxt;

    // Next-state, path enables and the status captured on entry to REPORT
    always_comb begin
        w_state_nxt  = r_state;
        w_in_open    = 1'b0;
        w_out_open   = 1'b0;
        w_in_hs      = 1'b0;
        w_out_hs     = 1'b0;
        w_idle       = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_in_open  = (r_in_cnt < r_in_words);
                w_out_open = (r_out_cnt < r_out_words);
                w_in_hs    = w_in_open & bus.src_valid & bus.ready_i;
                w_out_hs   = w_out_open & bus.valid_o & bus.snk_ready;
                w_idle     = ~w_in_hs & ~w_out_hs & ~bus.done;
                // Completion looks only at registered counts/flags, so a late done still waits a cycle
                w_complete = r_done_seen & (r_in_cnt == r_in_words) & (r_out_cnt == r_out_words);
                w_timeout  = TO_EN & w_idle & (r_to_cnt == TO_LAST);
                if (w_timeout) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = ST_TO;
                end else if (w_complete) begin
                    w_state_nxt  = S_REPORT;
                    w_status_nxt = (r_rej_seen | bus.sign_reject) ? ST_REJ : ST_OK;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latches, word counters, sticky core flags, idle timer and status
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_mode      <= 2'b00;
            r_in_words  <= {CNT_W{1'b0}};
            r_out_words <= {CNT_W{1'b0}};
            r_in_cnt    <= {CNT_W{1'b0}};
            r_out_cnt   <= {CNT_W{1'b0}};
            r_done_seen <= 1'b0;
            r_rej_seen  <= 1'b0;
            r_to_cnt    <= {TO_W{1'b0}};
            r_status    <= 2'b00;
        end else begin
            r_status <= w_status_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_mode      <= bus.cmd_mode;
                        r_in_words  <= bus.cmd_in_words;
                        r_out_words <= bus.cmd_out_words;
                        r_in_cnt    <= {CNT_W{1'b0}};
                        r_out_cnt   <= {CNT_W{1'b0}};
                        r_done_seen <= 1'b0;
                        r_rej_seen  <= 1'b0;
                        r_to_cnt    <= {TO_W{1'b0}};
                    end
                end
                S_START: begin
                    if (bus.sign_reject) begin
                        r_rej_seen <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_in_hs) begin
                        r_in_cnt <= r_in_cnt + CNT_ONE;
                    end
                    if (w_out_hs) begin
                        r_out_cnt <= r_out_cnt + CNT_ONE;
                    end
                    if (bus.done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (bus.sign_reject) begin
                        r_rej_seen <= 1'b1;
                    end
                    if (TO_EN && w_idle && !w_timeout) begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end else begin
                        r_to_cnt <= {TO_W{1'b0}};
                    end
                end
                default: begin
                    r_to_cnt <= r_to_cnt;
                end
            endcase
        end
    end

    // Zero-latency pass-through; both paths are closed outside STREAM
    assign bus.valid_i    = w_in_open & bus.src_valid;
    assign bus.src_ready  = w_in_open & bus.ready_i;
    assign bus.data_i     = bus.src_data;
    assign bus.ready_o    = w_out_open & bus.snk_ready;
    assign bus.snk_valid  = w_out_open & bus.valid_o;
    assign bus.snk_data   = bus.data_o;
    assign bus.snk_last   = w_out_open & bus.valid_o & (r_out_cnt == (r_out_words - CNT_ONE));

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.start      = (r_state == S_START);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rsp_valid  = (r_state == S_REPORT);
    assign bus.rsp_status = r_status;
    assign bus.mode       = r_mode;

endmodule

// File: tb/tb_dilithium_host_driver.sv
// Directed bench for dilithium_host_driver: a cycle-stepped source/core/sink model
// drives each command and checks pass-through data, framing, latency and status.
module tb_dilithium_host_driver;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    dilithium_host_driver_if #(.CNT_W(16)) bus ();

    dilithium_host_driver #(
        .CNT_W   (16),
        .TIMEOUT (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {start,valid_i,ready_o,src_ready,snk_valid,snk_last,rsp_valid,busy,mode,rsp_status,cmd_ready}
    function automatic logic [31:0] out_vec();
        return 32'({bus.start, bus.valid_i, bus.ready_o, bus.src_ready, bus.snk_valid,
                    bus.snk_last, bus.rsp_valid, bus.busy, bus.mode, bus.rsp_status, bus.cmd_ready});
    endfunction

    task automatic run_cmd(input string nm, input logic [1:0] m, input int in_w, input int out_w,
                           input int core_n, input int done_at, input bit rej, input int bp,
                           input logic [1:0] exp_st, input int exp_cyc);
        int          src_idx      = 0;
        int          core_sent    = 0;
        int          done_cyc     = -1;
        int          last_hs      = -1;
        int          rsp_cyc      = -1;
        int          exp_rsp;
        bit          done_given   = 1'b0;
        bit          surplus_seen = 1'b0;
        bit          give_done;
        logic [1:0]  got_st       = 2'b00;
        logic [31:0] exp_cnt;

        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_mode      = m;
        bus.cmd_in_words  = 16'(in_w);
        bus.cmd_out_words = 16'(out_w);
        bus.src_valid     = 1'b1;
        bus.ready_i       = 1'b1;
        bus.snk_ready     = 1'b1;
        bus.valid_o       = 1'b0;
        #1 check({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        // START cycle: single start pulse, mode visible, input path still closed
        #1 check({nm, "_start_cycle"},
                 32'({bus.start, bus.busy, bus.cmd_ready, bus.valid_i, bus.src_ready, bus.mode}),
                 32'({3'b110, 2'b00, m}));

        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            give_done = !done_given && (done_at != -2) &&
                        ((done_at == -1) ? (src_idx == in_w && core_sent == core_n)
                                         : (core_sent == done_at));
            bus.done        = give_done;
            bus.sign_reject = give_done & rej;
            bus.src_valid   = (bp == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.src_data    = 32'hA000_0000 + 32'(src_idx);
            bus.ready_i     = (bp == 2) ? 1'b0 : ((bp == 1) ? ($urandom_range(0, 2) != 0) : 1'b1);
            bus.valid_o     = !give_done && (core_sent < core_n);
            bus.data_o      = 32'hC000_0000 + 32'(core_sent);
            bus.snk_ready   = (bp == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                got_st  = bus.rsp_status;
                check({nm, "_report_gate"},
                      32'({bus.valid_i, bus.src_ready, bus.ready_o, bus.snk_valid,
                           bus.start, bus.cmd_ready, bus.busy}), 32'h01);
                break;
            end
            if (cyc == 0) check({nm, "_start_once"}, 32'(bus.start), 32'd0);
            if (give_done) begin
                done_given = 1'b1;
                done_cyc   = cyc;
            end
            if (bus.valid_i && bus.ready_i) begin
                check({nm, "_data_i"}, bus.data_i, 32'hA000_0000 + 32'(src_idx));
                src_idx++;
                last_hs = cyc;
            end
            if (bus.valid_o && bus.ready_o) begin
                check({nm, "_snk_flags"}, 32'({bus.snk_valid, bus.snk_last}),
                      32'({1'b1, (core_sent == out_w - 1)}));
                check({nm, "_snk_data"}, bus.snk_data, 32'hC000_0000 + 32'(core_sent));
                core_sent++;
                last_hs = cyc;
            end else if (bus.valid_o && core_sent >= out_w && !surplus_seen) begin
                check({nm, "_surplus_ready_o"}, 32'(bus.ready_o), 32'd0);
                surplus_seen = 1'b1;
            end
        end

        exp_rsp = (exp_cyc >= 0) ? exp_cyc : (((done_cyc > last_hs) ? done_cyc : last_hs) + 2);
        exp_cnt = (exp_st == 2'b10) ? 32'd0 : 32'({16'(in_w), 16'(out_w)});
        check({nm, "_rsp_cycle"}, 32'(rsp_cyc), 32'(exp_rsp));
        check({nm, "_status"}, 32'(got_st), 32'(exp_st));
        check({nm, "_word_counts"}, 32'({16'(src_idx), 16'(core_sent)}), exp_cnt);
        check({nm, "_surplus_seen"}, 32'(surplus_seen), 32'(core_n > out_w));

        @(negedge clk);
        bus.done        = 1'b0;
        bus.sign_reject = 1'b0;
        bus.valid_o     = 1'b0;
        #1 check({nm, "_after_rsp"}, 32'({bus.rsp_valid, bus.busy, bus.cmd_ready}), 32'h1);
    endtask

    initial begin
        rst               = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_mode      = 2'b00;
        bus.cmd_in_words  = 16'd0;
        bus.cmd_out_words = 16'd0;
        bus.src_valid     = 1'b0;
        bus.src_data      = 32'd0;
        bus.snk_ready     = 1'b0;
        bus.ready_i       = 1'b0;
        bus.valid_o       = 1'b0;
        bus.data_o        = 32'd0;
        bus.done          = 1'b0;
        bus.sign_reject   = 1'b0;

        repeat (2) @(negedge clk);
        #1 check("reset_outputs", out_vec(), 32'h1);
        rst = 1'b1;

        run_cmd("nominal",  2'd2, 4, 3, 3, -1, 1'b0, 0, 2'b00, -1);
        run_cmd("reject",   2'd1, 2, 1, 1, -1, 1'b1, 0, 2'b01, -1);
        run_cmd("backpres", 2'd3, 8, 8, 8, -1, 1'b0, 1, 2'b00, -1);
        run_cmd("earlydone", 2'd0, 1, 2, 3, 1, 1'b0, 0, 2'b00, -1);
        run_cmd("timeout",  2'd1, 2, 1, 0, -2, 1'b0, 2, 2'b10, 16);

        // Reset in the middle of STREAM with every input asserted
        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_mode      = 2'd3;
        bus.cmd_in_words  = 16'd4;
        bus.cmd_out_words = 16'd4;
        bus.src_valid     = 1'b1;
        bus.ready_i       = 1'b1;
        bus.valid_o       = 1'b1;
        bus.snk_ready     = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        #1 check("midrst_streaming", 32'({bus.valid_i, bus.ready_o, bus.busy}), 32'h7);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("midrst_outputs", out_vec(), 32'h1);
        rst         = 1'b1;
        bus.valid_o = 1'b0;
        bus.src_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("midrst_no_rsp", 32'({bus.rsp_valid, bus.busy, bus.cmd_ready}), 32'h1);
        end

        run_cmd("zerolen", 2'd2, 0, 0, 0, -1, 1'b0, 0, 2'b00, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dilithium_host_driver.md
# dilithium_host_driver

Host-side initiator for the Dilithium core's streaming interface (`start`/`mode`/`valid_i`/`ready_i`/`data_i`/`valid_o`/`ready_o`/`data_o`/`done`/`sign_reject`).

- Accepts one command at a time, pulses `start`, and streams input words from an upstream source into the core.
- Collects output words into a downstream sink with a `last` marker.
- Reports a completion status word once the core signals done, or when a stall timeout expires.
- Sits between an SoC/DMA word stream and the Dilithium top so the core can be driven without a CPU polling loop.

## Interface
- `CNT_W`, 16: width of word counters and command length fields.
- `TIMEOUT`, 1048576: consecutive idle cycles (no handshake, no done) in STREAM before abort. 0 disables.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_mode` in 2: operation mode, forwarded unchanged to the core.
- `cmd_in_words` in CNT_W: number of words to send to the core.
- `cmd_out_words` in CNT_W: number of words to collect from the core.
- `src_valid` in 1, `src_ready` out 1, `src_data` in 32: upstream input words.
- `snk_valid` out 1, `snk_ready` in 1, `snk_data` out 32, `snk_last` out 1: downstream output words.
- `start` out 1: one-cycle start pulse to the core.
- `mode` out 2: mode to the core.
- `valid_i` out 1, `ready_i` in 1, `data_i` out 32: core input stream.
- `valid_o` in 1, `ready_o` out 1, `data_o` in 32: core output stream.
- `done` in 1: core completion.
- `sign_reject` in 1: core rejection flag.
- `busy` out 1: high from command accept until the cycle after `rsp_valid`.
- `rsp_valid` out 1: one-cycle pulse with the final status.
- `rsp_status` out 2: 00 ok, 01 sign_reject, 10 timeout.

## Operation
- **FSM states:** IDLE, START, STREAM, REPORT.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch mode, in_words and out_words; clear in_cnt, out_cnt, done_seen, rej_seen and the timeout counter; go to START.
- **START:** `start`=1 for exactly this cycle; go to STREAM.
- **STREAM, input path (combinational pass-through):**
  - `valid_i` = `src_valid` & (in_cnt<in_words).
  - `src_ready` = `ready_i` & (in_cnt<in_words).
  - `data_i` = `src_data`.
  - in_cnt increments on `valid_i`&`ready_i`.
- **STREAM, output path (combinational pass-through):**
  - `ready_o` = `snk_ready` & (out_cnt<out_words).
  - `snk_valid` = `valid_o` & (out_cnt<out_words).
  - `snk_data` = `data_o`.
  - `snk_last` = `snk_valid` & (out_cnt==out_words-1).
  - out_cnt increments on `valid_o`&`ready_o`.
- **Input and output are independent.** Both may handshake in the same cycle.
- **Done/reject latching:**
  - `done` high in STREAM sets done_seen.
  - `sign_reject` high in any cycle of START/STREAM sets rej_seen.
  - Both are sticky until the next command.
- **Go to REPORT** when done_seen & in_cnt==in_words & out_cnt==out_words, evaluated on registered values. A done arriving before the counts complete is latched, and collection continues.
- **Timeout:**
  - The counter increments each STREAM cycle with no handshake on either path and no `done`; it clears on any of these.
  - Reaching TIMEOUT goes to REPORT with status 10.
- **Status priority:** timeout > reject > ok.
- **REPORT:** `rsp_valid`=1 for one cycle; go to IDLE.
- **Core outputs are gated outside their states.** Outside STREAM, `valid_i`, `src_ready`, `ready_o` and `snk_valid` are 0.
- **Surplus core output is refused.** Words beyond out_words are not accepted (`ready_o`=0); the core back-pressures.
- **Zero-length counts:** in_words=0 or out_words=0 means that path is immediately complete.
- **Counter widths:** compares are unsigned CNT_W; counters never wrap because they stop at the limit.

## Timing
- **Reset values (rst=0 sampled at a clock edge):**
  - State IDLE; all counters and sticky flags 0.
  - `start`, `valid_i`, `ready_o`, `src_ready`, `snk_valid`, `snk_last`, `rsp_valid`, `busy` = 0; `mode`=0; `rsp_status`=0.
  - `cmd_ready`=1 from the first cycle after reset.
- **Reset mid-operation:** aborts immediately, with no `rsp_valid`.
- **Command to stream:** command accepted at edge N; `start`=1 during cycle N+1; stream paths open from cycle N+2.
- **Pass-through latency:** 0 cycles in both directions; no internal buffering.
- **Report latency:** the completion condition registers at edge M; `rsp_valid` is high during cycle M+1; `cmd_ready`=1 from cycle M+2.
- **Mode hold:** `mode` holds the latched value from START through REPORT and keeps it in IDLE until the next command.
- **Core rules honoured:** data is held stable while `valid_i`&!`ready_i`, provided the source obeys the same rule.

## Test plan
- **Nominal run:** mode=2, in_words=4, out_words=3, src always valid, core ready, core returns 3 words then `done` → `start` exactly 1 cycle at N+1; 4 input handshakes; `snk_last` on the 3rd output; `rsp_valid` with status 00.
- **Back-pressure:** random `snk_ready`/`ready_i` stalls 0–5 cycles, in_words=8, out_words=8 → all 8 words pass in order, no duplicates or drops; status 00.
- **Sign reject:** in_words=2, out_words=1, `sign_reject`=1 with `done` → status 01; `cmd_ready` returns 2 cycles after completion.
- **Early done:** `done` pulses before the 2nd of 2 output words → driver still collects word 2, then reports 00. A 3rd surplus core word sees `ready_o`=0.
- **Timeout:** TIMEOUT=16, core never asserts `ready_i` → `rsp_status`=10 after 16 idle STREAM cycles.
- **Reset and zero length:** rst=0 mid-STREAM → all outputs at reset values next cycle, no `rsp_valid`. Then in_words=0, out_words=0 with `done` → status 00.
